// File: rtl/dm_obi_arb.sv
// Round-robin OBI arbiter: merges NrPorts upstream managers onto one debug-module port
// and routes in-order responses back through a small tracking FIFO.
module dm_obi_arb #(
  parameter int unsigned NrPorts        = 2,
  parameter int unsigned BusWidth       = 32,
  parameter int unsigned IdWidth        = 1,
  parameter int unsigned MaxOutstanding = 2
) (
  input  logic                                clk_i,
  input  logic                                rst_ni,
  input  logic [NrPorts-1:0]                  up_req_i,
  output logic [NrPorts-1:0]                  up_gnt_o,
  input  logic [NrPorts-1:0]                  up_we_i,
  input  logic [NrPorts-1:0][BusWidth-1:0]    up_addr_i,
  input  logic [NrPorts-1:0][BusWidth/8-1:0]  up_be_i,
  input  logic [NrPorts-1:0][BusWidth-1:0]    up_wdata_i,
  input  logic [NrPorts-1:0][IdWidth-1:0]     up_aid_i,
  output logic [NrPorts-1:0]                  up_rvalid_o,
  output logic [NrPorts-1:0][BusWidth-1:0]    up_rdata_o,
  output logic [NrPorts-1:0][IdWidth-1:0]     up_rid_o,
  output logic                                dn_req_o,
  output logic                                dn_we_o,
  output logic [BusWidth-1:0]                 dn_addr_o,
  output logic [BusWidth/8-1:0]               dn_be_o,
  output logic [BusWidth-1:0]                 dn_wdata_o,
  input  logic                                dn_gnt_i,
  input  logic                                dn_rvalid_i,
  input  logic [BusWidth-1:0]                 dn_rdata_i,
  output logic                                err_o
);

  localparam int unsigned PortW = (NrPorts > 1) ? $clog2(NrPorts) : 1;
  localparam int unsigned PtrW  = (MaxOutstanding > 1) ? $clog2(MaxOutstanding) : 1;
  localparam int unsigned CntW  = $clog2(MaxOutstanding + 1);

  logic [PortW-1:0] ptr_q, ptr_d;
  logic [PtrW-1:0]  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic             err_q, err_d;

  logic [PortW-1:0]   port_mem_q [MaxOutstanding];
  logic [IdWidth-1:0] id_mem_q   [MaxOutstanding];

  logic [PortW-1:0]   win_idx;
  logic               win_any;
  logic [PortW:0]     cand;
  logic               fifo_full, fifo_empty, can_accept, push, pop;
  logic [PortW-1:0]   head_port;
  logic [IdWidth-1:0] head_id;

  function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
    return (p == PtrW'(MaxOutstanding - 1)) ? '0 : p + PtrW'(1);
  endfunction

  // Scan from the priority pointer upwards, wrapping, and take the first requester.
  always_comb begin
    win_any = 1'b0;
    win_idx = '0;
    cand    = '0;
    for (int unsigned i = 0; i < NrPorts; i++) begin
      cand = {1'b0, ptr_q} + (PortW+1)'(i);
      if (cand >= (PortW+1)'(NrPorts)) begin
        cand = cand - (PortW+1)'(NrPorts);
      end
      if (!win_any && up_req_i[cand[PortW-1:0]]) begin
        win_any = 1'b1;
        win_idx = cand[PortW-1:0];
      end
    end
  end

  assign fifo_full  = (cnt_q == CntW'(MaxOutstanding));
  assign fifo_empty = (cnt_q == '0);
  assign pop        = dn_rvalid_i & ~fifo_empty;
  // A full FIFO can still take a request when a response frees a slot this cycle.
  assign can_accept = ~fifo_full | pop;
  assign dn_req_o   = rst_ni & win_any & can_accept;
  assign push       = dn_req_o & dn_gnt_i;

  assign dn_we_o    = dn_req_o & up_we_i[win_idx];
  assign dn_addr_o  = dn_req_o ? up_addr_i[win_idx]  : '0;
  assign dn_be_o    = dn_req_o ? up_be_i[win_idx]    : '0;
  assign dn_wdata_o = dn_req_o ? up_wdata_i[win_idx] : '0;

  assign head_port = port_mem_q[rd_ptr_q];
  assign head_id   = id_mem_q[rd_ptr_q];

  always_comb begin
    up_gnt_o    = '0;
    up_rvalid_o = '0;
    up_rdata_o  = '0;
    up_rid_o    = '0;
    for (int unsigned p = 0; p < NrPorts; p++) begin
      up_gnt_o[p] = push & (win_idx == PortW'(p));
      if (pop && (head_port == PortW'(p))) begin
        up_rvalid_o[p] = 1'b1;
        up_rdata_o[p]  = dn_rdata_i;
        up_rid_o[p]    = head_id;
      end
    end
  end

  always_comb begin
    ptr_d    = ptr_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    err_d    = err_q | (dn_rvalid_i & fifo_empty);
    if (push) begin
      ptr_d    = (win_idx == PortW'(NrPorts - 1)) ? '0 : win_idx + PortW'(1);
      wr_ptr_d = ptr_inc(wr_ptr_q);
    end
    if (pop) begin
      rd_ptr_d = ptr_inc(rd_ptr_q);
    end
    case ({push, pop})
      2'b10:   cnt_d = cnt_q + CntW'(1);
      2'b01:   cnt_d = cnt_q - CntW'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      ptr_q    <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
      err_q    <= 1'b0;
    end else begin
      ptr_q    <= ptr_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
      err_q    <= err_d;
    end
  end

  // Entry contents need no reset: only the pointers and count decide validity.
  always_ff @(posedge clk_i) begin
    if (push) begin
      port_mem_q[wr_ptr_q] <= win_idx;
      id_mem_q[wr_ptr_q]   <= up_aid_i[win_idx];
    end
  end

  assign err_o = err_q;

endmodule

// File: tb/tb_dm_obi_arb.sv
// Bench for dm_obi_arb: per-cycle vector table with a response scoreboard,
// followed by hand-written reset and error sequences.
module tb_dm_obi_arb;

  logic             clk = 1'b0;
  logic             rst_ni;
  logic [1:0]       up_req, up_gnt, up_we, up_rvalid;
  logic [1:0][31:0] up_addr, up_wdata, up_rdata;
  logic [1:0][3:0]  up_be;
  logic [1:0][0:0]  up_aid, up_rid;
  logic             dn_req, dn_we, dn_gnt, dn_rvalid, err;
  logic [31:0]      dn_addr, dn_wdata, dn_rdata;
  logic [3:0]       dn_be;

  always #5 clk = ~clk;

  dm_obi_arb #(.NrPorts(2), .BusWidth(32), .IdWidth(1), .MaxOutstanding(2)) dut (
    .clk_i(clk), .rst_ni(rst_ni),
    .up_req_i(up_req), .up_gnt_o(up_gnt), .up_we_i(up_we), .up_addr_i(up_addr),
    .up_be_i(up_be), .up_wdata_i(up_wdata), .up_aid_i(up_aid),
    .up_rvalid_o(up_rvalid), .up_rdata_o(up_rdata), .up_rid_o(up_rid),
    .dn_req_o(dn_req), .dn_we_o(dn_we), .dn_addr_o(dn_addr), .dn_be_o(dn_be),
    .dn_wdata_o(dn_wdata), .dn_gnt_i(dn_gnt), .dn_rvalid_i(dn_rvalid),
    .dn_rdata_i(dn_rdata), .err_o(err)
  );

  typedef struct {
    logic [1:0]  req;
    logic [1:0]  aid;
    logic        gnt;
    logic        rv;
    logic [31:0] rdata;
    logic        exp_req;
    int          exp_win;
  } vec_t;

  typedef struct {
    int   port;
    logic id;
  } sb_t;

  vec_t vecs[21];
  sb_t  sb[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   cyc      = 0;
  logic err_model = 1'b0;

  logic [31:0] addr_c  [2] = '{32'h0000_1000, 32'h0000_1100};
  logic [31:0] wdata_c [2] = '{32'hCAFE_0000, 32'hCAFE_0001};
  logic [3:0]  be_c    [2] = '{4'hF, 4'h3};
  logic        we_c    [2] = '{1'b1, 1'b0};

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s (cycle %0d): got %0h expected %0h", name, cyc, act, exp);
    end
  endtask

  // Drive one cycle at posedge+1, check at the following negedge, then update the model.
  task automatic run_cycle(input logic [1:0] req, input logic [1:0] aid, input logic gnt,
                           input logic rv, input logic [31:0] rdata,
                           input logic exp_req, input int exp_win);
    logic [1:0]       exp_gnt;
    logic [1:0]       exp_rv;
    logic [1:0][31:0] exp_rd;
    logic [1:0]       exp_rid;
    logic [68:0]      exp_pl;
    logic             was_empty;
    sb_t              e;
    up_req    = req;
    up_aid    = aid;
    dn_gnt    = gnt;
    dn_rvalid = rv;
    dn_rdata  = rdata;
    #4;
    exp_gnt = '0;
    exp_pl  = '0;
    if (exp_req) begin
      exp_pl = {we_c[exp_win], addr_c[exp_win], be_c[exp_win], wdata_c[exp_win]};
      if (gnt) exp_gnt[exp_win] = 1'b1;
    end
    exp_rv    = '0;
    exp_rd    = '0;
    exp_rid   = '0;
    was_empty = (sb.size() == 0);
    if (rv && !was_empty) begin
      e = sb.pop_front();
      exp_rv[e.port]  = 1'b1;
      exp_rd[e.port]  = rdata;
      exp_rid[e.port] = e.id;
    end
    check("dn_req", 128'(dn_req), 128'(exp_req));
    check("up_gnt", 128'(up_gnt), 128'(exp_gnt));
    check("dn_payload", 128'({dn_we, dn_addr, dn_be, dn_wdata}), 128'(exp_pl));
    check("up_rvalid", 128'(up_rvalid), 128'(exp_rv));
    check("up_rdata", 128'(up_rdata), 128'(exp_rd));
    check("up_rid", 128'(up_rid), 128'(exp_rid));
    check("err", 128'(err), 128'(err_model));
    $display("cyc %0d req=%b gnt=%b rv=%b -> dn_req=%b up_gnt=%b up_rvalid=%b err=%b",
             cyc, req, gnt, rv, dn_req, up_gnt, up_rvalid, err);
    if (exp_req && gnt) sb.push_back('{exp_win, aid[exp_win]});
    if (rv && was_empty) err_model = 1'b1;
    @(posedge clk);
    #1;
    cyc++;
  endtask

  // Hold reset for two edges with the given inputs active, checking outputs stay quiet.
  task automatic do_reset(input logic [1:0] req, input logic gnt, input logic rv);
    up_req    = req;
    dn_gnt    = gnt;
    dn_rvalid = rv;
    dn_rdata  = 32'h0BAD_0BAD;
    rst_ni    = 1'b0;
    sb.delete();
    err_model = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1;
    check("rst_up_gnt", 128'(up_gnt), 128'(0));
    check("rst_dn_req", 128'(dn_req), 128'(0));
    check("rst_up_rvalid", 128'(up_rvalid), 128'(0));
    check("rst_err", 128'(err), 128'(0));
    $display("reset applied req=%b gnt=%b rv=%b", req, gnt, rv);
    up_req    = '0;
    dn_gnt    = 1'b0;
    dn_rvalid = 1'b0;
    dn_rdata  = '0;
    rst_ni    = 1'b1;
  endtask

  initial begin
    // Alternating grants and in-order routing, then single-port read, FIFO-full
    // back-pressure, and a grant stall.
    vecs[0]  = '{2'b11, 2'b01, 1'b1, 1'b0, 32'h0,         1'b1,  0};
    vecs[1]  = '{2'b11, 2'b01, 1'b1, 1'b1, 32'h1111_0001, 1'b1,  1};
    vecs[2]  = '{2'b11, 2'b01, 1'b1, 1'b1, 32'h1111_0002, 1'b1,  0};
    vecs[3]  = '{2'b11, 2'b01, 1'b1, 1'b1, 32'h1111_0003, 1'b1,  1};
    vecs[4]  = '{2'b00, 2'b01, 1'b1, 1'b1, 32'h1111_0004, 1'b0, -1};
    vecs[5]  = '{2'b10, 2'b10, 1'b1, 1'b0, 32'h0,         1'b1,  1};
    vecs[6]  = '{2'b00, 2'b00, 1'b1, 1'b1, 32'hDEAD_BEEF, 1'b0, -1};
    vecs[7]  = '{2'b01, 2'b01, 1'b1, 1'b0, 32'h0,         1'b1,  0};
    vecs[8]  = '{2'b01, 2'b00, 1'b1, 1'b0, 32'h0,         1'b1,  0};
    vecs[9]  = '{2'b01, 2'b00, 1'b1, 1'b0, 32'h0,         1'b0, -1};
    vecs[10] = '{2'b01, 2'b00, 1'b1, 1'b0, 32'h0,         1'b0, -1};
    vecs[11] = '{2'b01, 2'b01, 1'b1, 1'b1, 32'h2222_0011, 1'b1,  0};
    vecs[12] = '{2'b00, 2'b00, 1'b1, 1'b1, 32'h2222_0012, 1'b0, -1};
    vecs[13] = '{2'b00, 2'b00, 1'b1, 1'b1, 32'h2222_0013, 1'b0, -1};
    vecs[14] = '{2'b10, 2'b00, 1'b1, 1'b0, 32'h0,         1'b1,  1};
    vecs[15] = '{2'b00, 2'b00, 1'b1, 1'b1, 32'h2222_0015, 1'b0, -1};
    vecs[16] = '{2'b11, 2'b00, 1'b0, 1'b0, 32'h0,         1'b1,  0};
    vecs[17] = '{2'b11, 2'b00, 1'b0, 1'b0, 32'h0,         1'b1,  0};
    vecs[18] = '{2'b11, 2'b00, 1'b0, 1'b0, 32'h0,         1'b1,  0};
    vecs[19] = '{2'b11, 2'b10, 1'b1, 1'b0, 32'h0,         1'b1,  0};
    vecs[20] = '{2'b00, 2'b00, 1'b1, 1'b1, 32'h2222_0020, 1'b0, -1};

    for (int p = 0; p < 2; p++) begin
      up_addr[p]  = addr_c[p];
      up_wdata[p] = wdata_c[p];
      up_be[p]    = be_c[p];
      up_we[p]    = we_c[p];
    end
    up_aid = '0;

    do_reset(2'b11, 1'b1, 1'b0);
    foreach (vecs[i]) begin
      run_cycle(vecs[i].req, vecs[i].aid, vecs[i].gnt, vecs[i].rv, vecs[i].rdata,
                vecs[i].exp_req, vecs[i].exp_win);
    end

    // Stray response after reset sets a sticky error.
    do_reset(2'b00, 1'b0, 1'b0);
    run_cycle(2'b00, 2'b00, 1'b0, 1'b1, 32'h5555_5555, 1'b0, -1);
    run_cycle(2'b00, 2'b00, 1'b0, 1'b0, 32'h0, 1'b0, -1);
    run_cycle(2'b00, 2'b00, 1'b0, 1'b0, 32'h0, 1'b0, -1);
    run_cycle(2'b11, 2'b00, 1'b1, 1'b0, 32'h0, 1'b1, 0);
    run_cycle(2'b00, 2'b00, 1'b0, 1'b1, 32'h6666_0001, 1'b0, -1);

    // Reset with two transactions outstanding discards them.
    do_reset(2'b00, 1'b0, 1'b0);
    run_cycle(2'b11, 2'b01, 1'b1, 1'b0, 32'h0, 1'b1, 0);
    run_cycle(2'b11, 2'b01, 1'b1, 1'b0, 32'h0, 1'b1, 1);
    run_cycle(2'b11, 2'b01, 1'b1, 1'b0, 32'h0, 1'b0, -1);
    do_reset(2'b11, 1'b1, 1'b1);
    run_cycle(2'b11, 2'b01, 1'b1, 1'b0, 32'h0, 1'b1, 0);
    run_cycle(2'b00, 2'b00, 1'b1, 1'b1, 32'h7777_0001, 1'b0, -1);
    run_cycle(2'b00, 2'b00, 1'b0, 1'b0, 32'h0, 1'b0, -1);
    run_cycle(2'b00, 2'b00, 1'b0, 1'b1, 32'h7777_0002, 1'b0, -1);
    run_cycle(2'b00, 2'b00, 1'b0, 1'b0, 32'h0, 1'b0, -1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/dm_obi_arb.md
DM_OBI_ARB -- requirements
Module: dm_obi_arb

Interface
REQ-001 SHALL have parameter NrPorts, default 2, number of upstream OBI managers (>=2).
REQ-002 SHALL have parameter BusWidth, default 32, address/data width.
REQ-003 SHALL have parameter IdWidth, default 1, upstream aid/rid width.
REQ-004 SHALL have parameter MaxOutstanding, default 2, response-tracking FIFO depth (>=1).
REQ-005 SHALL have port clk_i  input  1  clock.
REQ-006 SHALL have port rst_ni  input  1  reset, asynchronous, active-low.
REQ-007 SHALL have port up_req_i  input  NrPorts  per-port OBI request.
REQ-008 SHALL have port up_gnt_o  output  NrPorts  per-port grant.
REQ-009 SHALL have port up_we_i  input  NrPorts  per-port write enable.
REQ-010 SHALL have port up_addr_i  input  NrPorts x BusWidth  per-port address.
REQ-011 SHALL have port up_be_i  input  NrPorts x BusWidth/8  per-port byte enables.
REQ-012 SHALL have port up_wdata_i  input  NrPorts x BusWidth  per-port write data.
REQ-013 SHALL have port up_aid_i  input  NrPorts x IdWidth  per-port transaction id.
REQ-014 SHALL have port up_rvalid_o  output  NrPorts  per-port response valid.
REQ-015 SHALL have port up_rdata_o  output  NrPorts x BusWidth  per-port read data.
REQ-016 SHALL have port up_rid_o  output  NrPorts x IdWidth  per-port response id.
REQ-017 SHALL have ports dn_req_o/dn_we_o (1), dn_addr_o/dn_wdata_o (BusWidth), dn_be_o (BusWidth/8) as outputs; dn_gnt_i/dn_rvalid_i (1), dn_rdata_i (BusWidth) as inputs: the single OBI port to the debug module slave.
REQ-018 SHALL have port err_o  output  1  sticky flag: dn_rvalid_i with no outstanding transaction.

Function
REQ-019 SHALL arbitrate round-robin: the requesting port at or after priority pointer ptr_q (ascending index, wrapping at NrPorts) wins.
REQ-020 SHALL drive dn_req_o=1 when any up_req_i=1 and the FIFO can accept (count<MaxOutstanding, or count==MaxOutstanding with dn_rvalid_i=1 in the same cycle); dn_we/addr/be/wdata SHALL be the winner's, and zero when dn_req_o=0.
REQ-021 SHALL assert up_gnt_o[w]=dn_gnt_i & dn_req_o for winner w only, combinationally (zero-cycle grant path); all other up_gnt_o bits 0.
REQ-022 On a downstream handshake (dn_req_o & dn_gnt_i), SHALL push {w, up_aid_i[w]} to the FIFO and set ptr_q to (w+1) mod NrPorts.
REQ-023 ptr_q SHALL hold when no handshake occurs, including while requests are stalled by dn_gnt_i=0.
REQ-024 On dn_rvalid_i=1 with FIFO non-empty, SHALL pop the head {p, id} and drive, in that same cycle, up_rvalid_o[p]=1, up_rdata_o[p]=dn_rdata_i, up_rid_o[p]=id; all other ports up_rvalid_o=0.
REQ-025 up_rdata_o/up_rid_o SHALL be zero for ports whose up_rvalid_o=0.
REQ-026 Responses SHALL be returned in request order (in-order FIFO); simultaneous push and pop in one cycle SHALL leave the count unchanged.
REQ-027 dn_rvalid_i=1 with an empty FIFO SHALL produce no up_rvalid_o, leave the FIFO unchanged, and set err_o=1 until reset.
REQ-028 FIFO pointers SHALL wrap modulo MaxOutstanding; the count SHALL never exceed MaxOutstanding nor underflow.
REQ-029 With a DM slave granting every cycle and responding the cycle after grant, the arbiter SHALL sustain one transaction per cycle with MaxOutstanding>=1.

Reset
REQ-030 On rst_ni=0: ptr_q=0, FIFO empty (count 0), err_o=0, all up_rvalid_o=0; up_gnt_o and dn_req_o SHALL be 0 whenever rst_ni=0.
REQ-031 Reset asserted mid-transaction SHALL discard all outstanding entries; responses arriving after reset release SHALL trigger REQ-027.

Verification
REQ-032 NrPorts=2; both req=1 every cycle, dn_gnt_i=1, rvalid one cycle later -> grants alternate 0,1,0,1; each rvalid routed to its issuing port.
REQ-033 Port1 only, aid=1, read; dn_rdata_i=0xDEADBEEF -> up_rvalid_o=2'b10, up_rdata_o[1]=0xDEADBEEF, up_rid_o[1]=1, port0 outputs 0.
REQ-034 MaxOutstanding=2, dn_gnt_i=1, rvalid withheld -> two grants then dn_req_o=0; one rvalid pulse -> dn_req_o=1 in that same cycle.
REQ-035 dn_gnt_i=0 for 3 cycles with both requesting -> no up_gnt_o, ptr_q unchanged; first grant after release goes to port 0.
REQ-036 dn_rvalid_i=1 after reset with no request -> no up_rvalid_o, err_o=1 next cycle, stays 1.
REQ-037 Reset asserted with 2 outstanding -> up_rvalid_o=0 and err_o=0; after release the FIFO is empty and first grant goes to port 0.
